// File: rtl/vram_port_arbiter.sv
// Arbitrates one single-port image BRAM between the display scan reader
// (priority) and a FIFO-buffered host pixel writer with starvation relief.
module vram_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 3,
  parameter int MEM_DEPTH    = 12288,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 1023
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            disp_req,
  input  logic [ADDR_W-1:0]               disp_addr,
  output logic [DATA_W-1:0]               disp_rdata,
  output logic                            disp_valid,
  output logic                            disp_miss,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  output logic                            err_addr,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [ADDR_W:0] ADDR_END = MEM_DEPTH[ADDR_W:0];
  localparam logic [LW-1:0]   FULL     = LW'(FIFO_DEPTH);
  localparam logic [SW-1:0]   SMAX     = SW'(STARVE_LIMIT);

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_DISP = 2'd1;
  localparam logic [1:0] G_WR   = 2'd2;

  // Kind of display response travelling down the 2-stage return pipe
  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_READ = 2'd1;
  localparam logic [1:0] K_ZERO = 2'd2;
  localparam logic [1:0] K_MISS = 2'd3;

  logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] f_data [FIFO_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [SW-1:0]     starve;
  logic [1:0]        grant, kind, p1, p2;
  logic              disp_in, wr_in, accept, push, pop, empty, steal;

  assign wr_ready = !reset && (fifo_level < FULL);
  assign accept   = wr_valid & wr_ready;
  assign wr_in    = {1'b0, wr_addr} < ADDR_END;
  assign disp_in  = {1'b0, disp_addr} < ADDR_END;
  assign push     = accept & wr_in;
  assign empty    = (fifo_level == '0);
  assign steal    = (starve == SMAX) & !empty & disp_req;
  assign pop      = (grant == G_WR);

  always_comb begin
    grant = G_NONE;
    if (disp_req & disp_in & !steal)
      grant = G_DISP;
    else if (!empty & (!disp_req | !disp_in | steal))
      grant = G_WR;
  end

  always_comb begin
    kind = K_NONE;
    if (disp_req) begin
      if (!disp_in)   kind = K_ZERO;
      else if (steal) kind = K_MISS;
      else            kind = K_READ;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wp] <= wr_addr;
      f_data[wp] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      starve     <= '0;
      err_addr   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      p1         <= K_NONE;
      p2         <= K_NONE;
      disp_valid <= 1'b0;
      disp_miss  <= 1'b0;
      disp_rdata <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      err_addr   <= accept & !wr_in;

      if (empty || pop)
        starve <= '0;
      else if (starve != SMAX)
        starve <= starve + SW'(1);

      unique case (grant)
        G_DISP: begin
          mem_en   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= disp_addr;
        end
        G_WR: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= f_addr[rp];
          mem_wdata <= f_data[rp];
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase

      p1         <= kind;
      p2         <= p1;
      disp_valid <= (p2 != K_NONE);
      disp_miss  <= (p2 == K_MISS);
      if (p2 == K_READ)
        disp_rdata <= mem_rdata;
      else if (p2 == K_ZERO)
        disp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a write-first BRAM model.
// Inputs change and outputs are checked on the falling clock edge.
module tb_vram_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_rdata;
  logic          disp_valid, disp_miss;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          err_addr;
  logic [2:0]    fifo_level;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem [12288];

  int n_asserts = 0;
  int n_fail = 0;
  int miss_cnt = 0;
  int valid_cnt = 0;
  int we_cnt = 0;

  vram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(12288),
    .FIFO_DEPTH(4), .STARVE_LIMIT(7)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rdata(disp_rdata), .disp_valid(disp_valid),
    .disp_miss(disp_miss),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .err_addr(err_addr), .fifo_level(fifo_level),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (disp_miss)  miss_cnt++;
    if (disp_valid) valid_cnt++;
    if (mem_we)     we_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic put(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
  endtask

  initial begin
    int base, cnt, base_v, base_w;
    logic flag;
    logic [AW-1:0] pa [3];
    logic [DW-1:0] pd [3];
    pa[0] = 14'd5;   pd[0] = 3'b101;
    pa[1] = 14'd300; pd[1] = 3'b011;
    pa[2] = 14'd301; pd[2] = 3'b101;

    // reset state
    step();
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_valid", 32'(disp_valid), 0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", 32'(wr_ready), 1);

    // preload image words through the writer port
    for (int i = 0; i < 3; i++) begin
      put(pa[i], pd[i]);
      step();
    end
    wr_valid = 1'b0;
    repeat (4) step();
    chk("preload_level", 32'(fifo_level), 0);

    // 1: single display read
    disp_req = 1'b1; disp_addr = 14'd5;
    step();
    chk("t1_en", 32'(mem_en), 1);
    chk("t1_we", 32'(mem_we), 0);
    chk("t1_addr", 32'(mem_addr), 5);
    disp_req = 1'b0;
    step();
    chk("t1_early_valid", 32'(disp_valid), 0);
    step();
    chk("t1_valid", 32'(disp_valid), 1);
    chk("t1_rdata", 32'(disp_rdata), 32'b101);
    step();
    chk("t1_pulse_end", 32'(disp_valid), 0);

    // 2: writes drain in idle display cycles
    base = miss_cnt;
    flag = 1'b1;
    for (int i = 0; i < 12; i++) begin
      disp_req  = (i % 2 == 0);
      disp_addr = 14'd100;
      if (i < 4) begin
        if (!wr_ready) flag = 1'b0;
        put(14'(10 + i), 3'(1 + i));
      end else begin
        wr_valid = 1'b0;
      end
      step();
    end
    disp_req = 1'b0;
    step();
    chk("t2_ready_all", 32'(flag), 1);
    chk("t2_no_miss", 32'(miss_cnt - base), 0);
    chk("t2_level", 32'(fifo_level), 0);
    for (int a = 10; a < 14; a++) begin
      disp_req = 1'b1; disp_addr = 14'(a);
      step();
      disp_req = 1'b0;
      step();
      step();
      chk("t2_rb_valid", 32'(disp_valid), 1);
      chk("t2_rb_data", 32'(disp_rdata), 32'(a - 9));
    end

    // 3: FIFO fills while display holds the port
    disp_req = 1'b1; disp_addr = 14'd200;
    put(14'd20, 3'd5); step();
    put(14'd21, 3'd6); step();
    put(14'd22, 3'd7); step();
    put(14'd23, 3'd1); step();
    chk("t3_full_level", 32'(fifo_level), 4);
    chk("t3_not_ready", 32'(wr_ready), 0);
    put(14'd24, 3'd2);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!wr_ready && cnt < 20);
    chk("t3_slot_free_wait", 32'(cnt), 5);
    step();
    wr_valid = 1'b0;
    chk("t3_fifth_in", 32'(fifo_level), 4);
    disp_req = 1'b0;
    repeat (8) step();
    chk("t3_drained", 32'(fifo_level), 0);
    chk("t3_fifth_mem", 32'(mem[24]), 2);

    // 4: starvation steal with continuous display requests
    base = miss_cnt;
    disp_req = 1'b1; disp_addr = 14'd300;
    put(14'd30, 3'd6);
    step();
    wr_valid = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (mem_we) flag = 1'b1;
    end
    chk("t4_wait_no_we", 32'(flag), 0);
    disp_addr = 14'd301;
    step();
    chk("t4_steal_we", 32'(mem_we), 1);
    chk("t4_steal_addr", 32'(mem_addr), 30);
    chk("t4_steal_wdata", 32'(mem_wdata), 6);
    chk("t4_level", 32'(fifo_level), 0);
    disp_req = 1'b0;
    step();
    chk("t4_prev_valid", 32'(disp_valid), 1);
    chk("t4_prev_miss", 32'(disp_miss), 0);
    chk("t4_prev_data", 32'(disp_rdata), 3);
    step();
    chk("t4_miss_valid", 32'(disp_valid), 1);
    chk("t4_miss", 32'(disp_miss), 1);
    chk("t4_stale_data", 32'(disp_rdata), 3);
    step();
    chk("t4_miss_end", 32'(disp_miss), 0);
    chk("t4_miss_count", 32'(miss_cnt - base), 1);
    chk("t4_mem30", 32'(mem[30]), 6);

    // 5: out-of-range write and read
    put(14'd12288, 3'd7);
    step();
    wr_valid = 1'b0;
    chk("t5_err", 32'(err_addr), 1);
    chk("t5_level", 32'(fifo_level), 0);
    step();
    chk("t5_err_end", 32'(err_addr), 0);
    chk("t5_no_write", 32'(mem_en), 0);
    disp_req = 1'b1; disp_addr = 14'd12300;
    step();
    chk("t5_rd_no_en", 32'(mem_en), 0);
    disp_req = 1'b0;
    step();
    step();
    chk("t5_rd_valid", 32'(disp_valid), 1);
    chk("t5_rd_zero", 32'(disp_rdata), 0);
    chk("t5_rd_miss", 32'(disp_miss), 0);

    // 6: reset mid-pipeline; disp_rdata made nonzero first
    disp_req = 1'b1; disp_addr = 14'd300;
    put(14'd40, 3'd1); step();
    put(14'd41, 3'd2); step();
    put(14'd42, 3'd3); step();
    wr_valid = 1'b0;
    chk("t6_level3", 32'(fifo_level), 3);
    step();
    chk("t6_pre_rdata", 32'(disp_rdata), 3);
    #2 reset = 1'b1;
    #1;
    chk("t6_en", 32'(mem_en), 0);
    chk("t6_addr", 32'(mem_addr), 0);
    chk("t6_wdata", 32'(mem_wdata), 0);
    chk("t6_rdata", 32'(disp_rdata), 0);
    chk("t6_valid", 32'(disp_valid), 0);
    chk("t6_level", 32'(fifo_level), 0);
    chk("t6_ready", 32'(wr_ready), 0);
    disp_req = 1'b0;
    step();
    reset = 1'b0;
    #1;
    base_v = valid_cnt;
    base_w = we_cnt;
    repeat (6) step();
    #1;
    chk("t6_no_valid", 32'(valid_cnt - base_v), 0);
    chk("t6_no_write", 32'(we_cnt - base_w), 0);
    chk("t6_mem40", 32'(mem[40]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
